// File: rtl/snake_sfx_sequencer.sv
// Priority sound-effect sequencer driving the snake game's piezo beeper.
// Define SFX_PREEMPT_EN to let a higher-priority request restart an effect in progress.
module snake_sfx_sequencer #(
    parameter int unsigned NOTE_CYCLES = 5_000_000,
    parameter int unsigned GAP_CYCLES  = 1_000_000,
    parameter int unsigned DIV_SHIFT   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_eat,
    input  logic       req_start,
    input  logic       req_crash,
    input  logic       mute,
    output logic       beep,
    output logic       busy,
    output logic [1:0] active_id
);

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    localparam logic [15:0] HALF_DO = 16'd47774;
    localparam logic [15:0] HALF_RI = 16'd42568;
    localparam logic [15:0] HALF_MI = 16'd37919;
    localparam logic [15:0] HALF_FA = 16'd35791;
    localparam logic [15:0] HALF_SO = 16'd31888;
    localparam logic [15:0] HALF_XI = 16'd25309;

    localparam logic [31:0] NOTE_LAST = 32'(NOTE_CYCLES - 1);
    localparam logic [31:0] GAP_LAST  = (GAP_CYCLES == 0) ? 32'd0 : 32'(GAP_CYCLES - 1);

    state_t      state, state_n;
    logic [1:0]  id_q, id_n;
    logic [2:0]  idx_q, idx_n;
    logic [15:0] tone_cnt, tone_cnt_n;
    logic [31:0] dur_cnt, dur_cnt_n;
    logic [31:0] gap_cnt, gap_cnt_n;
    logic        tone_q, tone_n;
    logic [1:0]  req_id;
    logic [15:0] half;
    logic        last_note;

    function automatic logic [15:0] note_table(input logic [1:0] id, input logic [2:0] idx);
        logic [15:0] p;
        p = 16'd0;
        case (id)
            2'd1: p = (idx == 3'd0) ? HALF_SO : HALF_XI;
            2'd2: case (idx)
                      3'd0:    p = HALF_DO;
                      3'd1:    p = HALF_MI;
                      default: p = HALF_SO;
                  endcase
            2'd3: case (idx)
                      3'd0:    p = HALF_SO;
                      3'd1:    p = HALF_FA;
                      3'd2:    p = HALF_MI;
                      3'd3:    p = HALF_RI;
                      default: p = HALF_DO;
                  endcase
            default: p = 16'd0;
        endcase
        return p;
    endfunction

    always_comb begin
        req_id = 2'd0;
        if (req_crash)
            req_id = 2'd3;
        else if (req_start)
            req_id = 2'd2;
        else if (req_eat)
            req_id = 2'd1;
    end

    always_comb begin
        half = note_table(id_q, idx_q) >> DIV_SHIFT;
        case (id_q)
            2'd1:    last_note = (idx_q == 3'd1);
            2'd2:    last_note = (idx_q == 3'd2);
            2'd3:    last_note = (idx_q == 3'd4);
            default: last_note = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            id_q     <= 2'd0;
            idx_q    <= 3'd0;
            tone_cnt <= 16'd0;
            dur_cnt  <= 32'd0;
            gap_cnt  <= 32'd0;
            tone_q   <= 1'b0;
        end else begin
            state    <= state_n;
            id_q     <= id_n;
            idx_q    <= idx_n;
            tone_cnt <= tone_cnt_n;
            dur_cnt  <= dur_cnt_n;
            gap_cnt  <= gap_cnt_n;
            tone_q   <= tone_n;
        end
    end

    // Every note, including one following another with no gap, starts from a low tone level.
    always_comb begin
        state_n    = state;
        id_n       = id_q;
        idx_n      = idx_q;
        tone_cnt_n = tone_cnt;
        dur_cnt_n  = dur_cnt;
        gap_cnt_n  = gap_cnt;
        tone_n     = tone_q;
        case (state)
            IDLE: begin
                if (req_id != 2'd0) begin
                    state_n    = PLAY;
                    id_n       = req_id;
                    idx_n      = 3'd0;
                    tone_cnt_n = 16'd0;
                    dur_cnt_n  = 32'd0;
                    gap_cnt_n  = 32'd0;
                    tone_n     = 1'b0;
                end
            end
            PLAY: begin
                if (tone_cnt == half) begin
                    tone_n     = ~tone_q;
                    tone_cnt_n = 16'd0;
                end else begin
                    tone_cnt_n = tone_cnt + 16'd1;
                end
                dur_cnt_n = dur_cnt + 32'd1;
                if (dur_cnt == NOTE_LAST) begin
                    tone_n     = 1'b0;
                    tone_cnt_n = 16'd0;
                    dur_cnt_n  = 32'd0;
                    if (last_note) begin
                        state_n = IDLE;
                        id_n    = 2'd0;
                    end else if (GAP_CYCLES > 0) begin
                        state_n   = GAP;
                        gap_cnt_n = 32'd0;
                    end else begin
                        idx_n = idx_q + 3'd1;
                    end
                end
            end
            GAP: begin
                tone_n    = 1'b0;
                gap_cnt_n = gap_cnt + 32'd1;
                if (gap_cnt == GAP_LAST) begin
                    state_n    = PLAY;
                    idx_n      = idx_q + 3'd1;
                    tone_cnt_n = 16'd0;
                    dur_cnt_n  = 32'd0;
                    gap_cnt_n  = 32'd0;
                end
            end
            default: state_n = IDLE;
        endcase
`ifdef SFX_PREEMPT_EN
        // Effect ids double as priority, so a numerically larger request wins.
        if (state != IDLE && req_id > id_q) begin
            state_n    = PLAY;
            id_n       = req_id;
            idx_n      = 3'd0;
            tone_cnt_n = 16'd0;
            dur_cnt_n  = 32'd0;
            gap_cnt_n  = 32'd0;
            tone_n     = 1'b0;
        end
`endif
    end

    assign beep      = tone_q & ~mute;
    assign busy      = (state != IDLE);
    assign active_id = id_q;

endmodule

// File: tb/tb_snake_sfx_sequencer.sv
// Randomized and directed bench for snake_sfx_sequencer against a schedule-based reference model.
module tb_snake_sfx_sequencer;

    localparam int NC = 40;
    localparam int GC = 4;
    localparam int DS = 12;
    localparam int SLOT = NC + GC;
`ifdef SFX_PREEMPT_EN
    localparam bit PREEMPT = 1'b1;
`else
    localparam bit PREEMPT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_eat = 1'b0;
    logic       req_start = 1'b0;
    logic       req_crash = 1'b0;
    logic       mute = 1'b0;
    logic       beep;
    logic       busy;
    logic [1:0] active_id;

    int checks = 0;
    int passes = 0;
    int cycle = 0;
    int m_id = 0;
    int m_t = 0;

    snake_sfx_sequencer #(.NOTE_CYCLES(NC), .GAP_CYCLES(GC), .DIV_SHIFT(DS)) dut (
        .clk(clk), .rst(rst), .req_eat(req_eat), .req_start(req_start),
        .req_crash(req_crash), .mute(mute), .beep(beep), .busy(busy), .active_id(active_id)
    );

    always #5 clk = ~clk;

    function automatic int scale_half(input int note);
        case (note)
            0: return 47774;
            1: return 42568;
            2: return 37919;
            3: return 35791;
            4: return 31888;
            5: return 28410;
            default: return 25309;
        endcase
    endfunction

    function automatic int note_count(input int id);
        case (id)
            1: return 2;
            2: return 3;
            3: return 5;
            default: return 0;
        endcase
    endfunction

    function automatic int note_of(input int id, input int k);
        case (id)
            1: return (k == 0) ? 4 : 6;
            2: return 2 * k;
            default: return 4 - k;
        endcase
    endfunction

    function automatic int effect_len(input int id);
        return note_count(id) * NC + (note_count(id) - 1) * GC;
    endfunction

    // t = edges elapsed since the request was accepted
    function automatic int model_tone(input int id, input int t);
        int k, m, h;
        if (id == 0) return 0;
        k = t / SLOT;
        m = t % SLOT;
        if (m >= NC) return 0;
        h = scale_half(note_of(id, k)) >> DS;
        return (m / (h + 1)) % 2;
    endfunction

    task automatic checkOutput(input string tag, input int got, input int exp);
        checks++;
        if (got == exp) passes++;
        else $display("[TB] FAIL %s at cycle %0d: got %0d expected %0d", tag, cycle, got, exp);
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic s,
                                 input logic c, input logic m);
        int w, prev;
        rst = r; req_eat = e; req_start = s; req_crash = c; mute = m;
        @(posedge clk);
        w = c ? 3 : (s ? 2 : (e ? 1 : 0));
        prev = m_id;
        if (r) begin
            m_id = 0;
        end else begin
            if (m_id != 0) begin
                m_t++;
                if (m_t >= effect_len(m_id)) m_id = 0;
            end
            if (w != 0 && (prev == 0 || (PREEMPT && w > prev))) begin
                m_id = w;
                m_t = 0;
            end
        end
        #1;
        cycle++;
        checkOutput("busy", int'(busy), (m_id != 0) ? 1 : 0);
        checkOutput("active_id", int'(active_id), m_id);
        checkOutput("beep", int'(beep), m ? 0 : model_tone(m_id, m_t));
    endtask

    task automatic runIdle(input int n, input logic m);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, m);
    endtask

    initial begin
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_id", int'(active_id), 0);

        // Reset in the middle of a crash effect
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        runIdle(30, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("midreset_busy", int'(busy), 0);
        checkOutput("midreset_id", int'(active_id), 0);
        checkOutput("midreset_beep", int'(beep), 0);
        runIdle(20, 1'b0);
        checkOutput("postreset_quiet", int'(busy), 0);

        // Eat effect: rise at +8, gap at +40..+43, done at +84
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("eat_id", int'(active_id), 1);
        for (int i = 1; i <= 90; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            if (i == 7)  checkOutput("eat_pre_rise", int'(beep), 0);
            if (i == 8)  checkOutput("eat_rise", int'(beep), 1);
            if (i == 16) checkOutput("eat_fall", int'(beep), 0);
            if (i == 24) checkOutput("eat_rise2", int'(beep), 1);
            if (i >= 40 && i <= 43) checkOutput("eat_gap", int'(beep), 0);
            if (i == 51) checkOutput("xi_rise", int'(beep), 1);
            if (i == 65) checkOutput("xi_rise2", int'(beep), 1);
            if (i == 83) checkOutput("eat_busy_end", int'(busy), 1);
            if (i == 84) checkOutput("eat_done", int'(busy), 0);
        end

        // Simultaneous eat and crash: crash wins, 216 cycles
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("prio_id", int'(active_id), 3);
        for (int i = 1; i <= 220; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            if (i == 215) checkOutput("crash_busy_end", int'(busy), 1);
            if (i == 216) checkOutput("crash_done", int'(busy), 0);
        end

        // Crash arriving at cycle 20 of an eat effect
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        runIdle(19, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef SFX_PREEMPT_EN
        checkOutput("preempt_id", int'(active_id), 3);
        checkOutput("preempt_beep", int'(beep), 0);
        runIdle(7, 1'b0);
        checkOutput("preempt_pre_rise", int'(beep), 0);
        runIdle(1, 1'b0);
        checkOutput("preempt_rise", int'(beep), 1);
        runIdle(220, 1'b0);
`else
        checkOutput("nopreempt_id", int'(active_id), 1);
        runIdle(63, 1'b0);
        checkOutput("nopreempt_busy", int'(busy), 1);
        runIdle(1, 1'b0);
        checkOutput("nopreempt_done", int'(busy), 0);
        runIdle(10, 1'b0);
`endif

        // Eat during crash is dropped and never replayed
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        runIdle(49, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("drop_id", int'(active_id), 3);
        runIdle(200, 1'b0);
        checkOutput("no_replay", int'(busy), 0);

        // Muted eat effect keeps the same busy/active timing
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 90; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            if (i == 8)  checkOutput("mute_beep", int'(beep), 0);
            if (i == 83) checkOutput("mute_busy", int'(busy), 1);
            if (i == 84) checkOutput("mute_done", int'(busy), 0);
        end

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            applyStimulus(($urandom_range(0, 599) == 0),
                          ($urandom_range(0, 59) == 0),
                          ($urandom_range(0, 89) == 0),
                          ($urandom_range(0, 129) == 0),
                          ($urandom_range(0, 7) == 0));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
